// File: rtl/bs_sort4_ctrl_pkg.sv
// rtl/bs_sort4_ctrl_pkg.sv - shared state encoding and geometry for the 4-element sorter
package bs_sort4_ctrl_pkg;

  localparam int ELEM_W = 4;
  localparam int ELEM_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/BS_4_comp4.sv
// rtl/BS_4_comp4.sv - 4-bit unsigned magnitude comparator with LT/EQ/GT outputs
module BS_4_comp4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic       lt_o,
  output logic       eq_o,
  output logic       gt_o
);

  // Purely combinational; exactly one of the three outputs is high.
  always_comb begin
    lt_o = (a_i < b_i);
    eq_o = (a_i == b_i);
    gt_o = (a_i > b_i);
  end

endmodule

// File: rtl/bs_sort4_ctrl.sv
// rtl/bs_sort4_ctrl.sv - bubble sort of four 4-bit values on one shared comparator
module bs_sort4_ctrl
  import bs_sort4_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dir,
  input  logic [15:0] d,
  output logic [15:0] q,
  output logic        busy,
  output logic        done,
  output logic [2:0]  swap_count
);

  state_t                         state_q, state_d;
  logic [ELEM_N-1:0][ELEM_W-1:0]  r_q, r_d;
  logic                           dir_q, dir_d;
  logic [1:0]                     idx_q, idx_d;
  logic [1:0]                     pass_q, pass_d;
  logic                           swapped_q, swapped_d;
  logic [2:0]                     cnt_q, cnt_d;

  logic [ELEM_W-1:0]              cmp_a, cmp_b;
  logic                           cmp_lt, cmp_eq, cmp_gt;
  logic                           swap;
  logic                           pass_dirty;
  logic                           last_idx;

  // Pair select: the comparator always sees the neighbours at idx and idx+1.
  always_comb begin
    cmp_a = r_q[idx_q];
    cmp_b = r_q[idx_q + 2'd1];
  end

  BS_4_comp4 u_comp (
    .a_i  (cmp_a),
    .b_i  (cmp_b),
    .lt_o (cmp_lt),
    .eq_o (cmp_eq),
    .gt_o (cmp_gt)
  );

  // Swap only on a strict out-of-order result; equal keys stay put, keeping the sort stable.
  always_comb begin
    swap       = !cmp_eq && (dir_q ? cmp_lt : cmp_gt);
    pass_dirty = swapped_q || swap;
    last_idx   = (idx_q == (2'd2 - pass_q));
  end

  // Next-state and datapath updates: load on start, one compare per CMP cycle, early exit on a clean pass.
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    dir_d     = dir_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    swapped_d = swapped_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          r_d       = d;
          dir_d     = dir;
          cnt_d     = 3'd0;
          idx_d     = 2'd0;
          pass_d    = 2'd0;
          swapped_d = 1'b0;
          state_d   = ST_CMP;
        end
      end
      ST_CMP: begin
        if (swap) begin
          r_d[idx_q]        = cmp_b;
          r_d[idx_q + 2'd1] = cmp_a;
          cnt_d             = cnt_q + 3'd1;
        end
        if (last_idx) begin
          if (!pass_dirty || (pass_q == 2'd2)) begin
            state_d = ST_DONE;
          end else begin
            pass_d    = pass_q + 2'd1;
            idx_d     = 2'd0;
            swapped_d = 1'b0;
          end
        end else begin
          idx_d     = idx_q + 2'd1;
          swapped_d = pass_dirty;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything so q reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      r_q       <= '0;
      dir_q     <= 1'b0;
      idx_q     <= 2'd0;
      pass_q    <= 2'd0;
      swapped_q <= 1'b0;
      cnt_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      dir_q     <= dir_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      swapped_q <= swapped_d;
      cnt_q     <= cnt_d;
    end
  end

  assign q          = r_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign swap_count = cnt_q;

endmodule
